// File: rtl/fp_alu_pkg.sv
// rtl/fp_alu_pkg.sv - shared fp32 field constants and FSM state encodings
package fp_alu_pkg;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MANT_W = 23;
  localparam int FP32_BIAS   = 127;
  localparam logic [FP32_EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PACK  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/fp32_unpack.sv
// rtl/fp32_unpack.sv - splits an fp32 word into fields and classifies it
module fp32_unpack
  import fp_alu_pkg::*;
(
  input  logic [31:0]             i_fp,
  output logic                    o_sign,
  output logic [FP32_EXP_W-1:0]   o_exp,
  output logic [FP32_MANT_W:0]    o_mant_h,
  output logic                    o_is_zero,
  output logic                    o_is_denorm,
  output logic                    o_is_inf,
  output logic                    o_is_nan
);
  logic w_exp_zero;
  logic w_exp_max;
  logic w_mant_nz;

  assign o_sign      = i_fp[31];
  assign o_exp       = i_fp[30:23];
  assign w_exp_zero  = (o_exp == '0);
  assign w_exp_max   = (o_exp == EXP_SPECIAL);
  assign w_mant_nz   = (i_fp[22:0] != '0);
  assign o_mant_h    = {~w_exp_zero, i_fp[22:0]};
  assign o_is_zero   = w_exp_zero & ~w_mant_nz;
  assign o_is_denorm = w_exp_zero & w_mant_nz;
  assign o_is_inf    = w_exp_max & ~w_mant_nz;
  assign o_is_nan    = w_exp_max & w_mant_nz;
endmodule

// File: rtl/fp32_to_fixed.sv
// rtl/fp32_to_fixed.sv - iterative fp32 to signed fixed-point converter
module fp32_to_fixed
  import fp_alu_pkg::*;
#(
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_nan,
  output logic             out_inexact
);
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  logic                  w_sign;
  logic [FP32_EXP_W-1:0] w_exp;
  logic [FP32_MANT_W:0]  w_mant_h;
  logic                  w_is_zero, w_is_denorm, w_is_inf, w_is_nan;
  logic signed [9:0]     w_s;
  logic [9:0]            w_abs;
  logic                  w_too_big;

  logic [1:0]            r_state;
  logic [OUT_W-1:0]      r_mag;
  logic [9:0]            r_cnt;
  logic                  r_sign, r_left, r_sticky, r_nan, r_sat;
  logic [OUT_W-1:0]      r_out_data;
  logic                  r_ovf, r_nan_o, r_inexact;

  logic [OUT_W-1:0]      w_res;
  logic                  w_ovf, w_inex;

  fp32_unpack u_unpack (
    .i_fp        (in_data),
    .o_sign      (w_sign),
    .o_exp       (w_exp),
    .o_mant_h    (w_mant_h),
    .o_is_zero   (w_is_zero),
    .o_is_denorm (w_is_denorm),
    .o_is_inf    (w_is_inf),
    .o_is_nan    (w_is_nan)
  );

  // s is the left-shift distance that places the binary point at FRAC_W
  assign w_s       = {2'b00, w_exp} - 10'(FP32_BIAS + FP32_MANT_W) + 10'(FRAC_W);
  assign w_abs     = w_s[9] ? 10'(-w_s) : 10'(w_s);
  assign w_too_big = (w_s > 10'sd0) && (int'(w_s) + FP32_MANT_W >= OUT_W);

  always_comb begin
    w_res  = r_sign ? (~r_mag + 1'b1) : r_mag;
    w_ovf  = 1'b0;
    w_inex = r_sticky;
    if (r_nan) begin
      w_res  = '0;
      w_inex = 1'b0;
    end else if (r_sat || (r_sign ? (r_mag > MIN_NEG) : (r_mag > MAX_POS))) begin
      w_res  = r_sign ? MIN_NEG : MAX_POS;
      w_ovf  = 1'b1;
      w_inex = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mag      <= '0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_left     <= 1'b0;
      r_sticky   <= 1'b0;
      r_nan      <= 1'b0;
      r_sat      <= 1'b0;
      r_out_data <= '0;
      r_ovf      <= 1'b0;
      r_nan_o    <= 1'b0;
      r_inexact  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_sign   <= w_sign;
          r_mag    <= {{(OUT_W-FP32_MANT_W-1){1'b0}}, w_mant_h};
          r_cnt    <= w_abs;
          r_left   <= ~w_s[9];
          r_sticky <= 1'b0;
          r_nan    <= 1'b0;
          r_sat    <= 1'b0;
          r_state  <= ST_PACK;
          // Zero-result cases clear mag so PACK's negate of -0 stays 0
          if (w_is_nan) begin
            r_nan <= 1'b1;
            r_mag <= '0;
          end else if (w_is_inf) begin
            r_sat <= 1'b1;
          end else if (w_is_zero || w_is_denorm) begin
            r_mag    <= '0;
            r_sticky <= w_is_denorm;
          end else if (w_too_big) begin
            r_sat <= 1'b1;
          end else if (w_s < -10'sd24) begin
            r_mag    <= '0;
            r_sticky <= 1'b1;
          end else if (w_s != 10'sd0) begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (r_left) begin
            r_mag <= r_mag << 1;
          end else begin
            r_mag    <= r_mag >> 1;
            r_sticky <= r_sticky | r_mag[0];
          end
          r_cnt <= r_cnt - 10'd1;
          if (r_cnt == 10'd1) r_state <= ST_PACK;
        end
        ST_PACK: begin
          r_out_data <= w_res;
          r_ovf      <= w_ovf;
          r_nan_o    <= r_nan;
          r_inexact  <= w_inex;
          r_state    <= ST_DONE;
        end
        default: if (out_ready) r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign out_data    = r_out_data;
  assign out_ovf     = r_ovf;
  assign out_nan     = r_nan_o;
  assign out_inexact = r_inexact;
endmodule

// File: tb/tb_fp32_to_fixed.sv
// tb/tb_fp32_to_fixed.sv - directed self-checking bench for fp32_to_fixed
module tb_fp32_to_fixed;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf, out_nan, out_inexact;
  int          n_cmp = 0;
  int          n_err = 0;
  int          lat;
  logic        got;

  always #5 clk = ~clk;

  fp32_to_fixed #(.OUT_W(32), .FRAC_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
    .out_nan     (out_nan),
    .out_inexact (out_inexact)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Feeds one operand, waits for out_valid, checks result; leaves DUT in DONE
  task automatic convert(input string tag, input logic [31:0] d, input logic [31:0] e_data,
                         input logic e_ovf, input logic e_nan, input logic e_inex, input int e_lat);
    @(negedge clk);
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) got = 1'b1;
    end
    check({tag, ".valid"}, {31'd0, got}, 32'd1);
    check({tag, ".lat"}, lat, e_lat);
    check({tag, ".data"}, out_data, e_data);
    check({tag, ".flags"}, {29'd0, out_ovf, out_nan, out_inexact}, {29'd0, e_ovf, e_nan, e_inex});
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".drain"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.state", {30'd0, out_valid, in_ready}, 32'd1);
    check("rst.data", out_data, 32'd0);
    check("rst.flags", {29'd0, out_ovf, out_nan, out_inexact}, 32'd0);
    rst_n = 1'b1;

    convert("p3_0", 32'h40400000, 32'h00030000, 1'b0, 1'b0, 1'b0, 8);    release_out("p3_0");
    convert("m1_5", 32'hBFC00000, 32'hFFFE8000, 1'b0, 1'b0, 1'b0, 9);    release_out("m1_5");
    convert("p0_1", 32'h3DCCCCCD, 32'h00001999, 1'b0, 1'b0, 1'b1, 13);   release_out("p0_1");
    convert("p65000", 32'h477DE800, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 10); release_out("p65000");
    convert("m32768", 32'hC7000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 10); release_out("m32768");
    convert("huge", 32'h501502F9, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 2);    release_out("huge");
    convert("ninf", 32'hFF800000, 32'h80000000, 1'b1, 1'b0, 1'b0, 2);    release_out("ninf");
    convert("nan", 32'h7FC00000, 32'h00000000, 1'b0, 1'b1, 1'b0, 2);     release_out("nan");
    convert("nzero", 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 2);   release_out("nzero");
    convert("one", 32'h3F800000, 32'h00010000, 1'b0, 1'b0, 1'b0, 9);     release_out("one");
    convert("tiny", 32'h33800000, 32'h00000000, 1'b0, 1'b0, 1'b1, 2);    release_out("tiny");

    convert("bp", 32'h40400000, 32'h00030000, 1'b0, 1'b0, 1'b0, 8);
    in_data  = 32'hBFC00000;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp.hold", {30'd0, out_valid, in_ready}, 32'd2);
      check("bp.data", out_data, 32'h00030000);
      check("bp.flags", {29'd0, out_ovf, out_nan, out_inexact}, 32'd0);
    end
    in_valid = 1'b0;
    release_out("bp");

    convert("pre_rst", 32'h40400000, 32'h00030000, 1'b0, 1'b0, 1'b0, 8);
    release_out("pre_rst");
    in_data  = 32'h3DCCCCCD;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("mid.busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid.state", {30'd0, out_valid, in_ready}, 32'd1);
    check("mid.data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    convert("post_rst", 32'h40400000, 32'h00030000, 1'b0, 1'b0, 1'b0, 8);
    release_out("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fp32_to_fixed.md
Name: fp32_to_fixed

Overview:
Multi-cycle converter from IEEE-754 single precision to signed two's-complement fixed point (Q(OUT_W-FRAC_W).FRAC_W).
It is the return path for the ALU's 32-bit float results, back to integer/fixed-point consumers.
It uses an iterative one-bit-per-cycle shifter, truncation toward zero, saturation, and status flags.
Valid/ready handshake on both sides; one conversion in flight at a time.

Parameters:
OUT_W, 32, total output width in bits; legal values are 25 or more.
FRAC_W, 16, number of fractional bits; legal range is 0 to OUT_W-1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept; high only in IDLE
in_data  input  32  IEEE-754 single-precision operand
out_valid  output  1  result and flags are valid
out_ready  input  1  consumer accepts the result
out_data  output  OUT_W  signed fixed-point result
out_ovf  output  1  saturation occurred (includes ±inf)
out_nan  output  1  input was NaN
out_inexact  output  1  nonzero bits were discarded by truncation

Behaviour:
- Reset: state goes to IDLE, all data and flag outputs go to 0, and out_valid=0. Reset is asynchronous and applies in any state; an in-flight conversion is dropped without any output.
- States: IDLE, SHIFT, PACK, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch the sign, exponent e and mag={1,mantissa} (OUT_W-bit register).
  - Compute s = e - 127 - 23 + FRAC_W as a signed 10-bit value, and set cnt=|s|.
- Next state from IDLE:
  - e==255 with mantissa!=0 (NaN): go to PACK; result 0, nan=1.
  - e==255 with mantissa==0 (inf): go to PACK; saturate by sign, ovf=1.
  - e==0 (zero or denormal): go to PACK; result 0, inexact = (mantissa!=0). -0 yields 0.
  - s>0 and 23+s >= OUT_W: go to PACK; saturate, ovf=1, no shifting.
  - s<-24: go to PACK; result 0, inexact=1.
  - s==0: go to PACK.
  - Otherwise go to SHIFT.
- SHIFT:
  - Each cycle shift mag by one bit (left if s>0, right if s<0) and decrement cnt.
  - On a right shift, OR the bit shifted out into a sticky inexact.
  - When cnt reaches 1, go to PACK on that edge.
  - Shift cycles = |s|, at most max(24, OUT_W-24).
- PACK (1 cycle):
  - Positive input: if mag > 2^(OUT_W-1)-1, the result is 0x7FF..F and ovf=1.
  - Negative input: if mag > 2^(OUT_W-1), the result is 0x800..0 and ovf=1.
  - Otherwise the result is the sign-applied mag (two's-complement negate when the sign bit is set).
  - Exactly -2^(OUT_W-1) is representable and does not set ovf.
  - Register out_data and the flags, then go to DONE.
- DONE:
  - out_valid=1; out_data and flags are held stable.
  - On out_ready, go to IDLE; out_valid drops and in_ready rises on the same edge.
  - in_valid is ignored outside IDLE.
- Latency: out_valid rises |s|+2 rising edges after the accepting edge. Special and clamped cases take 2 edges.
- Throughput: one result per latency+1 cycles when out_ready is held high.
- Flags are mutually consistent: nan implies ovf=0 and inexact=0; ovf implies inexact=0.

Decomposition:
- Shared package fp_alu_pkg holds:
  - FP32_EXP_W=8, FP32_MANT_W=23, FP32_BIAS=127 and EXP_SPECIAL=8'hFF;
  - state encodings IDLE/SHIFT/PACK/DONE, which the int-to-float path reuses.
- One combinational sub-module, fp32_unpack, is natural. It splits sign, exponent and mantissa, inserts the hidden bit, and classifies is_zero/is_denorm/is_inf/is_nan. The ALU front end shares it.

Test Plan:
- 0x40400000 (3.0): s=-6 → out_data=0x00030000, no flags, out_valid 8 edges after accept.
- 0xBFC00000 (-1.5): out_data=0xFFFE8000, latency 9.
- 0x3DCCCCCD (0.1): out_data=0x00001999, inexact=1.
- 0x477DE800 (65000.0): s=8 → PACK overflow, out_data=0x7FFFFFFF, ovf=1.
- 0xC7000000 (-32768.0): out_data=0x80000000, ovf=0.
- 0x501502F9 → 0x7FFFFFFF with ovf=1 in 2 edges; 0xFF800000 (-inf) → 0x80000000 with ovf=1; 0x7FC00000 (NaN) → 0 with nan=1; 0x80000000 (-0) → 0, no flags.
- Backpressure: hold out_ready=0 for 5 cycles → out_data and flags stable, in_ready=0, a new in_valid is not accepted. Releasing out_ready gives in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 during SHIFT (input 0x3DCCCCCD) → immediately state IDLE, out_valid=0, out_data=0. After release, a fresh 3.0 converts correctly.
